// File: rtl/axi_console_pkg.sv
// Shared types and status-word layout for the AXI console transmitter.
package axi_console_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned STATUS_OFFSET  = 4;
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_LEVEL_LSB = 1;
    localparam int unsigned STAT_LEVEL_W   = 8;

    function automatic logic [31:0] status_word(input logic [STAT_LEVEL_W-1:0] level,
                                                input logic busy);
        logic [31:0] w;
        w = '0;
        w[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level;
        w[STAT_BUSY_BIT] = busy;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry an extra wrap bit to split full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (rd_ok) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axi_console_tx.sv
// AXI4-lite slave decoding console/pass-flag writes; console bytes go out on an 8N1 UART line.
module axi_console_tx
    import axi_console_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic        uart_tx,
    output logic        tests_passed,
    output logic        decode_err
);

    localparam int unsigned    LW          = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned    BW          = $clog2(CLK_DIV);
    localparam logic [BW-1:0]  BAUD_LAST   = BW'(CLK_DIV - 1);
    localparam logic [31:0]    STATUS_ADDR = CONSOLE_ADDR + STATUS_OFFSET;

    logic        aw_held, w_held, ar_pend;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic        w_strb0;
    logic        aw_hs, w_hs, ar_hs;
    logic        is_console, is_pass, want_push, exec, push;
    logic        fifo_full, fifo_empty, pop, tx_busy;
    logic [LW-1:0] fifo_level;
    logic [7:0]  fifo_head;

    tx_state_t   state;
    logic [BW-1:0] baud;
    logic        baud_last;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    logic        unused_bits;
    assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_wstrb[3:1]};

    assign aw_hs      = mem_axi_awvalid && mem_axi_awready;
    assign w_hs       = mem_axi_wvalid && mem_axi_wready;
    assign ar_hs      = mem_axi_arvalid && mem_axi_arready;
    assign is_console = (aw_addr == CONSOLE_ADDR);
    assign is_pass    = (aw_addr == PASS_ADDR);
    assign want_push  = is_console && w_strb0;
    // A console write into a full FIFO waits here until the transmitter pops.
    assign exec       = aw_held && w_held && !mem_axi_bvalid && !(want_push && fifo_full && !pop);
    assign push       = exec && want_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            aw_addr         <= '0;
            w_data          <= '0;
            w_strb0         <= 1'b0;
            mem_axi_awready <= 1'b0;
            mem_axi_wready  <= 1'b0;
            mem_axi_bvalid  <= 1'b0;
            tests_passed    <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= mem_axi_awaddr;
            end else if (exec) begin
                aw_held <= 1'b0;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                w_data  <= mem_axi_wdata;
                w_strb0 <= mem_axi_wstrb[0];
            end else if (exec) begin
                w_held <= 1'b0;
            end
            mem_axi_awready <= !(aw_hs || (aw_held && !exec));
            mem_axi_wready  <= !(w_hs || (w_held && !exec));

            if (exec) mem_axi_bvalid <= 1'b1;
            else if (mem_axi_bvalid && mem_axi_bready) mem_axi_bvalid <= 1'b0;

            if (exec && is_pass && (w_data == PASS_VALUE)) tests_passed <= 1'b1;
        end
    end

    // Reads: the address is taken on the handshake and answered on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_pend         <= 1'b0;
            ar_addr         <= '0;
            mem_axi_arready <= 1'b0;
            mem_axi_rvalid  <= 1'b0;
            mem_axi_rdata   <= '0;
            decode_err      <= 1'b0;
        end else begin
            ar_pend <= ar_hs;
            if (ar_hs) ar_addr <= mem_axi_araddr;
            if (ar_pend) begin
                mem_axi_rvalid <= 1'b1;
                mem_axi_rdata  <= (ar_addr == STATUS_ADDR) ?
                                  status_word(8'(fifo_level), tx_busy) : '0;
            end else if (mem_axi_rvalid && mem_axi_rready) begin
                mem_axi_rvalid <= 1'b0;
            end
            mem_axi_arready <= !(ar_hs || ar_pend || (mem_axi_rvalid && !mem_axi_rready));

            if ((exec && !is_console && !is_pass) || (ar_pend && (ar_addr != STATUS_ADDR)))
                decode_err <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (w_data[7:0]),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign baud_last = (baud == BAUD_LAST);
    // Popping at the end of STOP lets the next START follow with no idle gap.
    assign pop       = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && baud_last));
    assign tx_busy   = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
        end else if (pop) begin
            state   <= ST_START;
            shreg   <= fifo_head;
            baud    <= '0;
            uart_tx <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: uart_tx <= 1'b1;
                ST_START: begin
                    if (baud_last) begin
                        state   <= ST_DATA;
                        baud    <= '0;
                        bit_idx <= '0;
                        uart_tx <= shreg[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state   <= ST_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_last) state <= ST_IDLE;
                    else           baud  <= baud + BW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_console_tx.sv
// Directed bench for axi_console_tx: AXI transaction table plus hand-written UART/stall/reset sequences.
module tb_axi_console_tx;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] CONSOLE = 32'h1000_0000;
    localparam logic [31:0] STATUS  = 32'h1000_0004;
    localparam logic [31:0] PASS    = 32'h2000_0000;
    localparam logic [31:0] BAD     = 32'h3000_0000;
    localparam logic [31:0] PASSV   = 32'd123456789;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
    logic        arvalid = 0, arready, rvalid, rready = 1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        uart_tx, tests_passed, decode_err;

    always #5 clk = ~clk;

    axi_console_tx #(
        .CLK_DIV      (CLK_DIV),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CONSOLE_ADDR (CONSOLE),
        .PASS_ADDR    (PASS),
        .PASS_VALUE   (PASSV)
    ) dut (
        .clk (clk), .reset (reset),
        .mem_axi_awvalid (awvalid), .mem_axi_awready (awready),
        .mem_axi_awaddr (awaddr), .mem_axi_awprot (3'b000),
        .mem_axi_wvalid (wvalid), .mem_axi_wready (wready),
        .mem_axi_wdata (wdata), .mem_axi_wstrb (wstrb),
        .mem_axi_bvalid (bvalid), .mem_axi_bready (bready),
        .mem_axi_arvalid (arvalid), .mem_axi_arready (arready),
        .mem_axi_araddr (araddr), .mem_axi_arprot (3'b000),
        .mem_axi_rvalid (rvalid), .mem_axi_rready (rready),
        .mem_axi_rdata (rdata),
        .uart_tx (uart_tx), .tests_passed (tests_passed), .decode_err (decode_err)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART receiver: samples mid-bit on negedges, records bytes and idle samples before each start.
    logic [7:0] rx_q[$];
    int         gap_q[$];
    int         stop_bad = 0;
    initial begin
        logic [7:0] b;
        int idle_cnt;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset || uart_tx !== 1'b0) begin
                idle_cnt++;
            end else begin
                gap_q.push_back(idle_cnt);
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                if (uart_tx !== 1'b1) stop_bad++;
                rx_q.push_back(b);
                @(negedge clk);
                idle_cnt = 0;
            end
        end
    end

    // lat = cycles from the later AW/W handshake edge to bvalid.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output int lat);
        bit aw_d, w_d, aw_now, w_now;
        @(posedge clk); #1;
        awvalid = 1; awaddr = addr; wvalid = 1; wdata = data; wstrb = strb; bready = 1;
        aw_d = 0; w_d = 0;
        for (int n = 0; n < 200 && !(aw_d && w_d); n++) begin
            @(negedge clk);
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_now) begin awvalid = 0; aw_d = 1; end
            if (w_now)  begin wvalid = 0;  w_d = 1;  end
        end
        awvalid = 0; wvalid = 0;
        lat = 999;
        if (aw_d && w_d) begin
            for (int k = 1; k <= 200; k++) begin
                @(negedge clk);
                if (bvalid) begin lat = k - 1; break; end
            end
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        bit done, now;
        @(posedge clk); #1;
        arvalid = 1; araddr = addr; rready = 1; done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            now = arvalid && arready;
            @(posedge clk); #1;
            if (now) begin arvalid = 0; done = 1; end
        end
        arvalid = 0;
        lat = 999; data = 32'hDEAD_BEEF;
        if (done) begin
            for (int k = 1; k <= 100; k++) begin
                @(negedge clk);
                if (rvalid) begin lat = k - 1; data = rdata; break; end
            end
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int k = 0; k < budget && rx_q.size() < n; k++) @(negedge clk);
    endtask

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_tp;
        logic        exp_de;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] er,
                                input logic tp, input logic de);
        vec_t v;
        v.is_rd = r; v.addr = a; v.data = d; v.strb = s;
        v.exp_rdata = er; v.exp_tp = tp; v.exp_de = de;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish within 1ms");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vec_t        tbl[8];
        int          lat;
        logic [31:0] rd;
        logic [9:0]  fbits;
        logic [39:0] cap, exp40;
        logic [7:0]  exp_b;
        logic [6:0]  bv;
        bit          aw_now, w_now;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {uart_tx, awready, wready, arready, bvalid, rvalid, tests_passed, decode_err},
              8'b1000_0000);
        check("reset_rdata", rdata, 32'h0);
        reset = 0;
        @(negedge clk);
        check("ready_after_reset", {awready, wready, arready}, 3'b111);

        // ---- T1: single 0x41 frame ----
        axi_write(CONSOLE, 32'h41, 4'b0001, lat);
        check("t1_b_latency", lat, 1);
        check("t1_tx_before_start", uart_tx, 1'b1);
        exp_b = 8'h41;
        fbits = {1'b1, exp_b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cap[i] = uart_tx;
            exp40[i] = fbits[i / 4];
        end
        check("t1_frame", cap, exp40);
        @(negedge clk);
        check("t1_idle_after", uart_tx, 1'b1);
        wait_rx(1, 20);
        rx_q.delete(); gap_q.delete();

        // ---- T2: six back-to-back bytes into a 4-deep FIFO ----
        for (int i = 0; i < 6; i++) begin
            axi_write(CONSOLE, 32'(8'h11 * (i + 1)), 4'b0001, lat);
            if (i < 5) check($sformatf("t2_b_latency%0d", i), lat, 1);
            else       check("t2_stalled_write", (lat > 10 && lat < 999), 1'b1);
        end
        wait_rx(6, 400);
        check("t2_rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            check($sformatf("t2_rx_byte%0d", i), rx_q[i], 8'(8'h11 * (i + 1)));
        for (int i = 1; i < 6 && i < gap_q.size(); i++)
            check($sformatf("t2_gap%0d", i), gap_q[i], 0);
        repeat (8) @(negedge clk);
        rx_q.delete(); gap_q.delete();

        // ---- T3: transaction table ----
        tbl[0] = mk(1, STATUS,  32'h0,     4'hF, 32'h0, 1'b0, 1'b0);
        tbl[1] = mk(0, PASS,    32'd5,     4'hF, 32'h0, 1'b0, 1'b0);
        tbl[2] = mk(0, PASS,    PASSV,     4'hF, 32'h0, 1'b1, 1'b0);
        tbl[3] = mk(0, PASS,    32'd5,     4'hF, 32'h0, 1'b1, 1'b0);
        tbl[4] = mk(0, CONSOLE, 32'h55,    4'hE, 32'h0, 1'b1, 1'b0);
        tbl[5] = mk(1, STATUS,  32'h0,     4'hF, 32'h0, 1'b1, 1'b0);
        tbl[6] = mk(0, BAD,     32'h77,    4'hF, 32'h0, 1'b1, 1'b1);
        tbl[7] = mk(1, BAD,     32'h0,     4'hF, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_rd) begin
                axi_read(tbl[i].addr, rd, lat);
                check($sformatf("tbl%0d_r_latency", i), lat, 1);
                check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            end else begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, lat);
                check($sformatf("tbl%0d_b_latency", i), lat, 1);
            end
            check($sformatf("tbl%0d_flags", i), {tests_passed, decode_err},
                  {tbl[i].exp_tp, tbl[i].exp_de});
        end
        repeat (4) @(negedge clk);
        check("t3_no_push_on_strb0", rx_q.size(), 0);

        // ---- T7: reset clears sticky flags; bad read address flags decode_err ----
        @(negedge clk); reset = 1;
        repeat (2) @(negedge clk);
        check("t7_flags_cleared", {tests_passed, decode_err}, 2'b00);
        reset = 0;
        axi_read(32'h1234_5678, rd, lat);
        check("t7_bad_read_rdata", rd, 32'h0);
        check("t7_bad_read_flag", decode_err, 1'b1);

        // ---- T4: status while transmitting, then after drain ----
        for (int i = 0; i < 4; i++) axi_write(CONSOLE, 32'(8'h31 + i), 4'b0001, lat);
        axi_read(STATUS, rd, lat);
        check("t4_status_busy", rd, 32'h0000_0007);
        wait_rx(4, 300);
        repeat (4) @(negedge clk);
        axi_read(STATUS, rd, lat);
        check("t4_status_drained", rd, 32'h0);
        check("t4_rx_last", (rx_q.size() == 4) ? rx_q[3] : 8'hXX, 8'h34);
        rx_q.delete(); gap_q.delete();

        // ---- T5: reset mid-DATA bit ----
        axi_write(CONSOLE, 32'h00, 4'b0001, lat);
        axi_write(CONSOLE, 32'hB6, 4'b0001, lat);
        axi_write(CONSOLE, 32'hC7, 4'b0001, lat);
        @(negedge clk);
        check("t5_tx_low_in_data", uart_tx, 1'b0);
        reset = 1;
        #1;
        check("t5_tx_high_on_reset", uart_tx, 1'b1);
        repeat (2) @(negedge clk);
        reset = 0;
        axi_read(STATUS, rd, lat);
        check("t5_fifo_empty", rd, 32'h0);
        repeat (50) @(negedge clk);
        rx_q.delete(); gap_q.delete();
        axi_write(CONSOLE, 32'h3C, 4'b0001, lat);
        wait_rx(1, 100);
        repeat (10) @(negedge clk);
        check("t5_clean_count", rx_q.size(), 1);
        check("t5_clean_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hXX, 8'h3C);
        rx_q.delete(); gap_q.delete();

        // ---- T6: W two cycles before AW, bready held low ----
        @(posedge clk); #1;
        bready = 0; wvalid = 1; wdata = 32'h5A; wstrb = 4'b0001;
        @(negedge clk);
        check("t6_wready", wready, 1'b1);
        @(posedge clk); #1;
        wvalid = 0;
        @(posedge clk); #1;
        awvalid = 1; awaddr = CONSOLE;
        @(negedge clk);
        check("t6_awready", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 0;
        awvalid = 1; awaddr = CONSOLE; wvalid = 1; wdata = 32'h6B; wstrb = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bv[i] = bvalid;
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_now) awvalid = 0;
            if (w_now)  wvalid = 0;
        end
        check("t6_bvalid_held", bv, 7'b111_1110);
        check("t6_second_latched", {awvalid, wvalid}, 2'b00);
        axi_read(STATUS, rd, lat);
        check("t6_second_not_executed", rd, 32'h0000_0001);
        check("t6_bvalid_still", bvalid, 1'b1);
        @(posedge clk); #1;
        bready = 1;
        @(negedge clk);
        @(negedge clk);
        check("t6_bvalid_dropped", bvalid, 1'b0);
        @(negedge clk);
        check("t6_second_bvalid", bvalid, 1'b1);
        wait_rx(2, 200);
        check("t6_rx_count", rx_q.size(), 2);
        check("t6_rx_bytes", (rx_q.size() == 2) ? {rx_q[0], rx_q[1]} : 16'hXXXX, 16'h5A6B);
        check("t6_gap", (gap_q.size() == 2) ? gap_q[1] : -1, 0);
        check("uart_stop_bits", stop_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
